// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when that does not borrow.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;

    // rem_i < divisor_i always holds, so the restored remainder fits in WIDTH bits
    // and a modulo-WIDTH subtraction is exact.
    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {1'b0, divisor_i});
        rem_o   = q_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add/sub, iterative shift-add multiply
// and restoring divide, with a start/ready/done handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            oc,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] f,
    output logic [DATA_WIDTH-1:0] f_hi,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  flag_dz
);

    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         mcand_q, mcand_d;
    logic [2*W-1:0]       prod_q, prod_d;
    logic [W-1:0]         divisor_q, divisor_d;
    logic [W-1:0]         quo_q, quo_d;
    logic [W-1:0]         rem_q, rem_d;
    logic [W-1:0]         f_q, f_d, fhi_q, fhi_d;
    logic                 z_q, z_d, c_q, c_d, dz_q, dz_d, done_q, done_d;

    logic [W:0]           add_w;
    logic [W:0]           mul_sum;
    logic [W-1:0]         step_rem;
    logic                 step_q;

    assign add_w = {1'b0, a} + {1'b0, b};

    // Product register: upper half accumulates, lower half holds the
    // not-yet-consumed multiplier bits and fills with product LSBs.
    assign mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});

    div_step #(.WIDTH(W)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[W-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        f_d       = f_q;
        fhi_d     = fhi_q;
        c_d       = c_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (oc == OC_MUL) begin
                        mcand_d = a;
                        prod_d  = {{W{1'b0}}, b};
                        cnt_d   = CNT_WIDTH'(W);
                        state_d = ST_MUL;
                    end else if (oc == OC_DIV && b != '0) begin
                        divisor_d = b;
                        quo_d     = a;
                        rem_d     = '0;
                        cnt_d     = CNT_WIDTH'(W);
                        state_d   = ST_DIV;
                    end else begin
                        done_d = 1'b1;
                        fhi_d  = '0;
                        c_d    = 1'b0;
                        dz_d   = 1'b0;
                        case (oc)
                            OC_ADD: begin
                                f_d = add_w[W-1:0];
                                c_d = add_w[W];
                            end
                            OC_SUB: begin
                                f_d = a - b;
                                c_d = (a < b);
                            end
                            OC_DIV: begin
                                f_d   = '1;
                                fhi_d = a;
                                dz_d  = 1'b1;
                            end
                            OC_NOT:  f_d = ~a;
                            OC_XOR:  f_d = a ^ b;
                            OC_OR:   f_d = a | b;
                            default: f_d = a & b;
                        endcase
                    end
                end
            end
            ST_MUL: begin
                prod_d = {mul_sum, prod_q[W-1:1]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    f_d     = prod_d[W-1:0];
                    fhi_d   = prod_d[2*W-1:W];
                    c_d     = 1'b0;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DIV: begin
                rem_d = step_rem;
                quo_d = {quo_q[W-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    f_d     = quo_d;
                    fhi_d   = rem_d;
                    c_d     = 1'b0;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        z_d = done_d ? (f_d == '0) : z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            f_q       <= '0;
            fhi_q     <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            f_q       <= f_d;
            fhi_q     <= fhi_d;
            z_q       <= z_d;
            c_q       <= c_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign f       = f_q;
    assign f_hi    = fhi_q;
    assign flag_z  = z_q;
    assign flag_c  = c_q;
    assign flag_dz = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes reference results, monitor pops on done.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 16;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   oc = 3'b000;
    logic [W-1:0] a = '0, b = '0;
    logic         ready, done, flag_z, flag_c, flag_dz;
    logic [W-1:0] f, f_hi;

    alu_mc #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oc(oc), .a(a), .b(b),
        .ready(ready), .done(done), .f(f), .f_hi(f_hi),
        .flag_z(flag_z), .flag_c(flag_c), .flag_dz(flag_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] xa, xb, f, fhi;
        logic         z, c, dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wait_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain unsigned arithmetic on wide integers.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int now);
        exp_t e;
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned r = 0, hi = 0;
        int lat = 1;
        e.op = o; e.xa = x; e.xb = y; e.c = 1'b0; e.dz = 1'b0;
        case (o)
            OC_ADD: begin r = ux + uy; e.c = (r > MASK); end
            OC_SUB: begin r = ux - uy; e.c = (ux < uy); end
            OC_MUL: begin r = ux * uy; hi = r >> W; lat = W + 1; end
            OC_DIV: begin
                if (uy == 0) begin r = MASK; hi = ux; e.dz = 1'b1; end
                else begin r = ux / uy; hi = ux % uy; lat = W + 1; end
            end
            OC_NOT: r = ~ux;
            OC_XOR: r = ux ^ uy;
            OC_OR:  r = ux | uy;
            default: r = ux & uy;
        endcase
        e.f   = W'(r & MASK);
        e.fhi = W'(hi & MASK);
        e.z   = ((r & MASK) == 0);
        e.cyc = now + lat;
        return e;
    endfunction

    // Called just after a rising edge; waits for ready (optionally wiggling
    // inputs while busy), then presents one start for exactly one edge.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit noise);
        int guard = 0;
        while (!ready && guard < 200) begin
            if (noise) begin
                a = W'($urandom); b = W'($urandom);
                oc = 3'($urandom); start = 1'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        wait_cycles = guard;
        if (!ready) begin
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", guard);
            n_fail++;
            $fatal(1, "ready never returned");
        end
        start = 1'b1; oc = o; a = x; b = y;
        sb.push_back(model(o, x, y, cyc));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("txn oc=%0d a=0x%04h b=0x%04h -> f=0x%04h f_hi=0x%04h z=%0b c=%0b dz=%0b cyc=%0d",
                         e.op, e.xa, e.xb, f, f_hi, flag_z, flag_c, flag_dz, cyc);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("f", 64'(f), 64'(e.f));
                check("f_hi", 64'(f_hi), 64'(e.fhi));
                check("flag_z", 64'(flag_z), 64'(e.z));
                check("flag_c", 64'(flag_c), 64'(e.c));
                check("flag_dz", 64'(flag_dz), 64'(e.dz));
                check("ready_with_done", 64'(ready), 64'd1);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_f"}, 64'(f), 64'd0);
        check({tag, "_f_hi"}, 64'(f_hi), 64'd0);
        check({tag, "_flags"}, 64'({flag_z, flag_c, flag_dz}), 64'd0);
    endtask

    initial begin
        #12;
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops on consecutive cycles.
        do_op(OC_ADD, 16'hFFFF, 16'h0001, 1'b0);
        do_op(OC_SUB, 16'h0003, 16'h0005, 1'b0);
        do_op(OC_XOR, 16'hF0F0, 16'hFF00, 1'b0);
        drain();

        // Long multiply with noisy inputs, then a start in its done cycle.
        do_op(OC_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
        do_op(OC_NOT, 16'h00FF, W'($urandom), 1'b1);
        check("mul_busy_cycles", 64'(wait_cycles), 64'(W));

        do_op(OC_DIV, 16'd1000, 16'd7, 1'b0);
        do_op(OC_DIV, 16'h1234, 16'h0000, 1'b1);
        check("div_busy_cycles", 64'(wait_cycles), 64'(W));
        drain();

        // Asynchronous reset in the middle of a multiply.
        do_op(OC_MUL, W'($urandom), W'($urandom), 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_state("midop_reset");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check_reset_state("post_reset_idle");
        do_op(OC_ADD, 16'd2, 16'd3, 1'b0);
        drain();

        // Randomised mix, including divide-by-zero and extreme operands.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 3'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = '1;
                2: rb = '1;
                default: ;
            endcase
            do_op(ro, ra, rb, 1'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        n_fail++;
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, parametrised successor to the combinational ALU. It uses the same 3-bit opcode set.
- Simple ops (add, sub, not, xor, or, and) complete in one cycle.
- Mul is an iterative shift-add; div is an iterative restoring division.
- Produces a double-width result (high half = product MSBs or remainder) plus status flags, behind a start/ready/done handshake.
- Sits between the register file and the writeback stage of the datapath.

Parameters:
DATA_WIDTH, 16, operand/result width W (>=2); all arithmetic unsigned.
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
oc  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and
a  input  W  operand A, sampled at acceptance
b  input  W  operand B, sampled at acceptance
ready  output  1  1 = can accept start this cycle
done  output  1  one-cycle pulse: f/f_hi/flags valid and updated
f  output  W  result low half / quotient
f_hi  output  W  product high half, remainder, or 0
flag_z  output  1  f == 0
flag_c  output  1  add carry-out / sub borrow (a<b); 0 otherwise
flag_dz  output  1  div with b == 0

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; ready=1; done=0; f=0; f_hi=0; all flags 0; counter=0.
  - Any in-flight operation is discarded with no done.
- States are IDLE, MUL, DIV. ready = (state==IDLE).
- Acceptance = rising edge with start=1 and ready=1. oc/a/b are latched; later input changes are ignored. start while ready=0 is ignored (no queuing).
- Simple ops (000,001,100–111), IDLE at the acceptance edge:
  - f is the low W bits of the result; f_hi=0.
  - Flags are computed; done=1 in the next cycle; state stays IDLE.
  - Latency 1, throughput 1 per cycle; back-to-back starts give consecutive done pulses.
- Mul:
  - Acceptance edge: multiplicand/multiplier latched, accumulator cleared, counter=W, state→MUL, done=0.
  - Each MUL edge does one shift-add step and decrements the counter.
  - On the W-th step: f = product[W-1:0], f_hi = product[2W-1:W], done=1, state→IDLE.
  - done is visible W+1 cycles after the start cycle. flag_c=0.
- Div, b≠0:
  - Acceptance edge: state→DIV.
  - W restoring steps follow: remainder shifts left with the next dividend bit, trial subtract, quotient bit set if no borrow.
  - Final step: f=quotient, f_hi=remainder, done=1, state→IDLE. Latency W+1.
- Div, b==0:
  - Short-circuit at the acceptance edge: f = all ones, f_hi = a, flag_dz=1, done=1 next cycle, state stays IDLE. Latency 1.
- flag_z always reflects the new f. flag_dz=0 for all other ops.
- f, f_hi and flags hold their values between done pulses and update only at the done-producing edge.
- ready is low throughout MUL/DIV and returns to 1 in the same cycle as done. A start in the done cycle is accepted.
- Undefined opcodes do not exist (all 8 codes are used). No X may propagate from unused registers.

Decomposition:
- Package alu_pkg holds:
  - localparams OC_ADD, OC_SUB, OC_MUL, OC_DIV, OC_NOT, OC_XOR, OC_OR, OC_AND;
  - the state enum (ST_IDLE, ST_MUL, ST_DIV).
- One natural sub-module: div_step, a combinational single restoring-division iteration.
  - Inputs: rem, dividend bit, divisor.
  - Outputs: next rem, quotient bit.
- The shift-add mul step and the simple ops stay inline.

Test Plan:
- Reset mid-operation: start mul, assert rst_n=0 at cycle 5 → ready=1, done never pulses, f=0, f_hi=0, flags 0; next add 2+3 → f=5 one cycle later.
- Back-to-back simple ops (W=16), starts on consecutive cycles:
  - add 0xFFFF+0x0001 → f=0x0000, flag_z=1, flag_c=1;
  - sub 3-5 → f=0xFFFE, flag_c=1;
  - xor 0xF0F0^0xFF00 → f=0x0FF0;
  - done high three consecutive cycles.
- mul 0xFFFF*0xFFFF → done exactly 17 cycles after the start cycle, f=0x0001, f_hi=0xFFFE; ready low 16 cycles; a/b toggled during MUL have no effect.
- div 1000/7 → f=142, f_hi=6, latency 17; start pulses during DIV ignored.
- div 0x1234/0 → f=0xFFFF, f_hi=0x1234, flag_dz=1, latency 1.
- New start in the done cycle of a mul, then not 0x00FF → accepted; f=0xFF00 one cycle later.
